casez_match_table: RTL and testbench

- Programmable wildcard priority matcher: the runtime-configurable, parametrised successor to fixed casez/casex priority decoders.
- Holds ENTRIES (value, care-mask) pairs written through a config port.
- Each accepted key is compared against all enabled entries. Returns the lowest-index hit through a registered valid/ready output stage.
- Sits in front of decode/dispatch logic that previously used hard-coded casez tables.

---
 rtl/casez_match_table.sv | 158 +++++++++++++++
 tb/tb_casez_match_table.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/casez_match_table.sv
// Programmable wildcard priority matcher.
// ENTRIES (value, care, enable) slots are compared against each accepted key.
// The lowest-index enabled hit is returned through a single registered
// valid/ready output stage.

// One table slot: stores its pattern and flags whether the key hits it.
module casez_match_entry #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] wr_val,
    input  logic [WIDTH-1:0] wr_care,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] key,
    output logic             hit
);

    logic [WIDTH-1:0] val_q, val_d;
    logic [WIDTH-1:0] care_q, care_d;
    logic             en_q, en_d;

    // Load the slot on a decoded write, otherwise hold.
    always_comb begin
        val_d  = val_q;
        care_d = care_q;
        en_d   = en_q;
        if (we) begin
            val_d  = wr_val;
            care_d = wr_care;
            en_d   = wr_en;
        end
    end

    // Slot storage; reset leaves the slot disabled and all-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q  <= '0;
            care_q <= '0;
            en_q   <= 1'b0;
        end else begin
            val_q  <= val_d;
            care_q <= care_d;
            en_q   <= en_d;
        end
    end

    // Only bits with care=1 must agree; care=0 bits are wildcards.
    assign hit = en_q && (((key ^ val_q) & care_q) == '0);

endmodule

module casez_match_table #(
    parameter int WIDTH   = 3,
    parameter int ENTRIES = 4,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [WIDTH-1:0] cfg_val,
    input  logic [WIDTH-1:0] cfg_care,
    input  logic             cfg_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [IDX_W-1:0] out_idx
);

    // One extra bit so the range check also works when ENTRIES is a power of 2.
    localparam logic [IDX_W:0] ENTRIES_X = (IDX_W + 1)'(ENTRIES);

    logic               cfg_idx_ok;
    logic [ENTRIES-1:0] ent_we;
    logic [ENTRIES-1:0] ent_hit;
    logic               hit_any;
    logic [IDX_W-1:0]   idx_sel;
    logic               accept;

    logic               out_valid_q, out_valid_d;
    logic               out_hit_q, out_hit_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;

    // Out-of-range indices (non-power-of-2 tables) must not alias onto a slot.
    assign cfg_idx_ok = ({1'b0, cfg_idx} < ENTRIES_X);

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_ent
            assign ent_we[gi] = cfg_we && cfg_idx_ok && (cfg_idx == IDX_W'(gi));

            casez_match_entry #(.WIDTH(WIDTH)) u_ent (
                .clk     (clk),
                .rst_n   (rst_n),
                .we      (ent_we[gi]),
                .wr_val  (cfg_val),
                .wr_care (cfg_care),
                .wr_en   (cfg_en),
                .key     (in_key),
                .hit     (ent_hit[gi])
            );
        end
    endgenerate

    // Priority encode: scanning downward lets the lowest hit index win.
    always_comb begin
        hit_any = 1'b0;
        idx_sel = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ent_hit[i]) begin
                hit_any = 1'b1;
                idx_sel = IDX_W'(i);
            end
        end
    end

    // The output register is free when empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Capture a lookup on accept; drop valid once drained with nothing new.
    // A stalled result is held, never recomputed against a newer table.
    always_comb begin
        out_valid_d = out_valid_q;
        out_hit_d   = out_hit_q;
        out_idx_d   = out_idx_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_hit_d   = hit_any;
            out_idx_d   = idx_sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage register; reset drops any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_casez_match_table.sv
// Bench for casez_match_table: default 3x4 table driven by directed and
// random traffic against a table/handshake model, plus an 8-bit 5-entry
// instance for the non-power-of-2 sweep.
module tb_casez_match_table;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT A: WIDTH=3, ENTRIES=4 ----------------
    logic       a_cfg_we, a_cfg_en, a_in_valid, a_in_ready;
    logic [1:0] a_cfg_idx, a_out_idx;
    logic [2:0] a_cfg_val, a_cfg_care, a_in_key;
    logic       a_out_valid, a_out_ready, a_out_hit;

    casez_match_table u_a (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(a_cfg_we), .cfg_idx(a_cfg_idx), .cfg_val(a_cfg_val),
        .cfg_care(a_cfg_care), .cfg_en(a_cfg_en),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_key(a_in_key),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_hit(a_out_hit), .out_idx(a_out_idx)
    );

    // ---------------- DUT B: WIDTH=8, ENTRIES=5 ----------------
    logic       b_cfg_we, b_cfg_en, b_in_valid, b_in_ready;
    logic [2:0] b_cfg_idx, b_out_idx;
    logic [7:0] b_cfg_val, b_cfg_care, b_in_key;
    logic       b_out_valid, b_out_ready, b_out_hit;

    casez_match_table #(.WIDTH(8), .ENTRIES(5)) u_b (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx), .cfg_val(b_cfg_val),
        .cfg_care(b_cfg_care), .cfg_en(b_cfg_en),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_key(b_in_key),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_hit(b_out_hit), .out_idx(b_out_idx)
    );

    // ---------------- Reference model for DUT A ----------------
    logic [2:0] m_val  [4];
    logic [2:0] m_care [4];
    logic       m_en   [4];
    logic       e_valid, e_hit;
    logic [1:0] e_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int e = 0; e < 4; e++) begin
            m_val[e] = '0; m_care[e] = '0; m_en[e] = 1'b0;
        end
        e_valid = 1'b0; e_hit = 1'b0; e_idx = '0;
    endtask

    // Scan entries in index order; first enabled entry whose cared bits agree wins.
    task automatic lookup(input logic [2:0] key, output logic hit, output logic [1:0] idx);
        logic ok;
        hit = 1'b0; idx = '0;
        for (int e = 0; e < 4; e++) begin
            if (!hit && m_en[e]) begin
                ok = 1'b1;
                for (int b = 0; b < 3; b++)
                    if (m_care[e][b] && (key[b] != m_val[e][b])) ok = 1'b0;
                if (ok) begin hit = 1'b1; idx = 2'(e); end
            end
        end
    endtask

    // One clock on DUT A with current inputs; model predicts and checks.
    task automatic cyc(input string tag);
        logic rdy, acc, h;
        logic [1:0] ix;
        #1;
        rdy = !e_valid || a_out_ready;
        chk({tag, ".in_ready"}, a_in_ready, rdy);
        acc = a_in_valid && rdy;
        lookup(a_in_key, h, ix);
        if (a_cfg_we) begin
            m_val[a_cfg_idx] = a_cfg_val; m_care[a_cfg_idx] = a_cfg_care; m_en[a_cfg_idx] = a_cfg_en;
        end
        if (acc) begin e_valid = 1'b1; e_hit = h; e_idx = ix; end
        else if (a_out_ready) e_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".out_valid"}, a_out_valid, e_valid);
        if (e_valid) begin
            chk({tag, ".out_hit"}, a_out_hit, e_hit);
            chk({tag, ".out_idx"}, a_out_idx, e_idx);
        end
    endtask

    task automatic a_write(input logic [1:0] i, input logic [2:0] v, input logic [2:0] c, input logic en);
        a_cfg_we = 1'b1; a_cfg_idx = i; a_cfg_val = v; a_cfg_care = c; a_cfg_en = en;
        cyc("wr");
        a_cfg_we = 1'b0;
    endtask

    task automatic a_key(input string tag, input logic [2:0] k);
        a_in_valid = 1'b1; a_in_key = k;
        cyc(tag);
    endtask

    // One clock on DUT B with constant expectations from the directed table.
    task automatic cycb(input string tag, input logic ev, input logic eh, input logic [2:0] ei);
        @(posedge clk); #1;
        chk({tag, ".out_valid"}, b_out_valid, ev);
        if (ev) begin
            chk({tag, ".out_hit"}, b_out_hit, eh);
            chk({tag, ".out_idx"}, b_out_idx, ei);
        end
    endtask

    logic [1:0] st_idx [8];
    logic       st_hit [8];

    initial begin
        st_idx = '{2'd0, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
        st_hit = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        model_clear();
        rst_n = 1'b0;
        a_cfg_we = 0; a_cfg_idx = 0; a_cfg_val = 0; a_cfg_care = 0; a_cfg_en = 0;
        a_in_valid = 0; a_in_key = 0; a_out_ready = 1;
        b_cfg_we = 0; b_cfg_idx = 0; b_cfg_val = 0; b_cfg_care = 0; b_cfg_en = 0;
        b_in_valid = 0; b_in_key = 0; b_out_ready = 1;
        @(posedge clk); #1;
        chk("rst.out_valid", a_out_valid, 1'b0);
        chk("rst.out_hit", a_out_hit, 1'b0);
        chk("rst.out_idx", a_out_idx, 2'd0);
        chk("rst.in_ready", a_in_ready, 1'b1);
        rst_n = 1'b1;

        // Empty table: everything misses.
        a_key("empty", 3'b101);

        // Priority table.
        a_in_valid = 1'b0;
        a_write(2'd0, 3'b100, 3'b100, 1'b1);
        a_write(2'd1, 3'b010, 3'b110, 1'b1);
        a_write(2'd2, 3'b001, 3'b111, 1'b1);
        a_write(2'd3, 3'b111, 3'b000, 1'b0);
        a_key("k101", 3'b101); chk("k101.spec", {a_out_hit, a_out_idx}, 3'b1_00);
        a_key("k111", 3'b111); chk("k111.spec", {a_out_hit, a_out_idx}, 3'b1_00);
        a_key("k011", 3'b011); chk("k011.spec", {a_out_hit, a_out_idx}, 3'b1_01);
        a_key("k001", 3'b001); chk("k001.spec", {a_out_hit, a_out_idx}, 3'b1_10);
        a_key("k000", 3'b000); chk("k000.spec", {a_out_hit, a_out_idx}, 3'b0_00);

        // Back-pressure: hold a result, offer another key meanwhile.
        a_key("bp.k011", 3'b011);
        a_out_ready = 1'b0; a_in_key = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cyc("bp.hold");
            chk("bp.stable", {a_out_valid, a_out_idx}, 3'b1_01);
            chk("bp.in_ready", a_in_ready, 1'b0);
        end
        a_out_ready = 1'b1;
        cyc("bp.release");
        chk("bp.new", {a_out_valid, a_out_hit}, 2'b1_0);

        // Collision: disable e0 in the same cycle key 101 is accepted.
        a_cfg_we = 1'b1; a_cfg_idx = 2'd0; a_cfg_val = 3'b100; a_cfg_care = 3'b100; a_cfg_en = 1'b0;
        a_key("col.same", 3'b101);
        chk("col.same.spec", {a_out_hit, a_out_idx}, 3'b1_00);
        a_cfg_we = 1'b0;
        a_key("col.next", 3'b101);
        chk("col.next.spec", a_out_hit, 1'b0);
        a_in_valid = 1'b0;
        a_write(2'd0, 3'b100, 3'b100, 1'b1);

        // Streaming 000..111 back-to-back.
        for (int k = 0; k < 8; k++) begin
            a_key("stream", 3'(k));
            chk("stream.spec", {a_out_valid, a_out_hit, a_out_idx}, {1'b1, st_hit[k], st_idx[k]});
        end
        a_in_valid = 1'b0;
        cyc("drain");

        // Random traffic with occasional reprogramming.
        for (int n = 0; n < 400; n++) begin
            a_cfg_we   = ($urandom_range(0, 7) == 0);
            a_cfg_idx  = 2'($urandom_range(0, 3));
            a_cfg_val  = 3'($urandom);
            a_cfg_care = 3'($urandom);
            a_cfg_en   = ($urandom_range(0, 3) != 0);
            a_in_valid = ($urandom_range(0, 3) != 0);
            a_in_key   = 3'($urandom);
            a_out_ready = ($urandom_range(0, 3) != 0);
            cyc("rand");
        end
        a_cfg_we = 1'b0;

        // Reset mid-traffic with a stalled result pending.
        a_out_ready = 1'b0;
        a_write(2'd0, 3'b000, 3'b000, 1'b1);
        a_key("pre_rst", 3'b101);
        chk("pre_rst.valid", a_out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.out_valid", a_out_valid, 1'b0);
        chk("mid_rst.out_hit", a_out_hit, 1'b0);
        chk("mid_rst.out_idx", a_out_idx, 2'd0);
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        a_key("post_rst", 3'b101);
        chk("post_rst.miss", {a_out_valid, a_out_hit}, 2'b1_0);
        a_in_valid = 1'b0;

        // Parameter sweep on the 8-bit, 5-entry instance.
        b_cfg_we = 1'b1; b_cfg_idx = 3'd4; b_cfg_val = 8'hA5; b_cfg_care = 8'hFF; b_cfg_en = 1'b1;
        cycb("b.wr4", 1'b0, 1'b0, 3'd0);
        b_cfg_we = 1'b0; b_in_valid = 1'b1; b_in_key = 8'hA5;
        cycb("b.kA5", 1'b1, 1'b1, 3'd4);
        b_in_valid = 1'b0;
        b_cfg_we = 1'b1; b_cfg_idx = 3'd6; b_cfg_val = 8'hA4; b_cfg_care = 8'hFF; b_cfg_en = 1'b1;
        cycb("b.wr6", 1'b0, 1'b0, 3'd0);
        b_cfg_we = 1'b0; b_in_valid = 1'b1; b_in_key = 8'hA4;
        cycb("b.kA4", 1'b1, 1'b0, 3'd0);
        b_in_key = 8'hA5;
        cycb("b.kA5b", 1'b1, 1'b1, 3'd4);
        b_in_valid = 1'b0;
        cycb("b.drain", 1'b0, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
